// File: rtl/instr_mem_loader.sv
// Byte-addressed instruction memory with a hardware clear sequence, a
// valid/ready byte-stream load port and a registered, fault-reporting fetch
// port. Instructions are big-endian: the lowest-addressed byte is the MSB.
module instr_mem_loader #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 256,
    parameter int INSTR_BYTES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic                     instr_valid,
    output logic [1:0]               fetch_fault,
    output logic                     mem_ready,
    input  logic                     load_start,
    input  logic [ADDR_W-1:0]        load_base,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    output logic                     load_ready,
    input  logic                     load_done,
    output logic                     load_overflow
);

    localparam int IW    = 8 * INSTR_BYTES;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    // Pointer arithmetic is one bit wider than the address so that
    // "address + size" and the saturated load pointer never wrap.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [ADDR_W:0] STEP_L  = (ADDR_W+1)'(INSTR_BYTES);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH_BYTES - INSTR_BYTES);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_LOAD
    } state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] clear_ptr;
    logic [ADDR_W:0] load_ptr;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            load_xfer;
    logic            load_in_range;
    logic            fetch_go;
    logic [ADDR_W:0] fetch_end;
    logic            f_mis;
    logic            f_oor;
    logic [IW-1:0]   rd_word;

    assign mem_ready     = (state == S_RUN);
    assign load_ready    = (state == S_LOAD);
    assign load_xfer     = load_ready && load_valid;
    assign load_in_range = (load_ptr < DEPTH_L);
    assign fetch_go      = mem_ready && fetch_en;

    assign fetch_end = {1'b0, fetch_addr} + STEP_L;
    assign f_mis     = (fetch_addr % ADDR_W'(INSTR_BYTES)) != '0;
    assign f_oor     = (fetch_end > DEPTH_L);

    // Assemble the big-endian instruction word starting at fetch_addr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_word = '0;
        for (int b = 0; b < INSTR_BYTES; b++) begin
            rd_word[IW-1-8*b -: 8] = mem[IDX_W'(fetch_addr[IDX_W-1:0] + IDX_W'(b))];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CLEAR;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic: clear walks the whole array once, load runs until load_done.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clear_ptr == LAST_L) state_nxt = S_RUN;
            S_RUN:   if (load_start)          state_nxt = S_LOAD;
            S_LOAD:  if (load_done)           state_nxt = S_RUN;
            default:                          state_nxt = S_CLEAR;
        endcase
    end

    // Pointers, overflow flag and the registered fetch result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_ptr     <= '0;
            load_ptr      <= '0;
            load_overflow <= 1'b0;
            instr         <= '0;
            fetch_fault   <= '0;
            instr_valid   <= 1'b0;
        end else begin
            instr_valid <= fetch_go;
            if (fetch_go) begin
                fetch_fault <= {f_oor, f_mis};
                instr       <= (f_oor || f_mis) ? '0 : rd_word;
            end
            case (state)
                S_CLEAR: clear_ptr <= clear_ptr + STEP_L;
                S_RUN: begin
                    if (load_start) begin
                        load_ptr      <= {1'b0, load_base};
                        load_overflow <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_xfer) begin
                        if (load_in_range) load_ptr      <= load_ptr + 1'b1;
                        else               load_overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory write port: zero fill during CLEAR, byte stream during LOAD.
    // NOTE: the array has no reset; the CLEAR sequence initialises it so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            for (int b = 0; b < INSTR_BYTES; b++) begin
                mem[IDX_W'(clear_ptr[IDX_W-1:0] + IDX_W'(b))] <= 8'h00;
            end
        end else if (load_xfer && load_in_range) begin
            mem[load_ptr[IDX_W-1:0]] <= load_data;
        end
    end

endmodule
